lcd_meas_scheduler: RTL and testbench

Sequences periodic ADC conversions of the four converter measurements (Vin, Vout, Iout, Temp) over a single shared req/ack ADC port and holds a coherent snapshot for the LCD display path. Sits between the ADC interface and the LCD top level. The display splits each 8-bit output into the H nibble `[7:4]` and the L nibble `[3:0]`. A one-cycle update strobe marks each committed snapshot so the display sees all four values change together.

---
 rtl/lcd_meas_pkg.sv | 23 ++
 rtl/lcd_meas_scheduler_if.sv | 26 ++
 rtl/meas_tick_gen.sv | 31 +++
 rtl/lcd_meas_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_lcd_meas_scheduler.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_meas_pkg.sv
// Shared types and constants for the LCD measurement scheduler.
//   meas_state_e : scan FSM states
//   CH_*         : ADC channel numbers (also index the shadow/output arrays)
//   STALE_VAL    : value written for a channel whose conversion timed out
package lcd_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    NEXT   = 2'd2,
    COMMIT = 2'd3
  } meas_state_e;

  localparam int unsigned NUM_CH = 4;

  localparam logic [1:0] CH_VIN  = 2'd0;
  localparam logic [1:0] CH_VOUT = 2'd1;
  localparam logic [1:0] CH_IOUT = 2'd2;
  localparam logic [1:0] CH_TEMP = 2'd3;

  localparam logic [7:0] STALE_VAL = 8'hFF;

endpackage

// File: rtl/lcd_meas_scheduler_if.sv
// Shared req/ack ADC port between the measurement scheduler and the ADC.
//   oADC_REQ  : conversion request (scheduler -> ADC)
//   oADC_CH   : channel select, stable while oADC_REQ is high
//   iADC_ACK  : single-cycle completion pulse (ADC -> scheduler)
//   iADC_DATA : conversion result, valid with iADC_ACK
// master = scheduler side, slave = ADC side.
interface lcd_meas_scheduler_if;
  logic       oADC_REQ;
  logic [1:0] oADC_CH;
  logic       iADC_ACK;
  logic [7:0] iADC_DATA;

  modport master (
    output oADC_REQ,
    output oADC_CH,
    input  iADC_ACK,
    input  iADC_DATA
  );

  modport slave (
    input  oADC_REQ,
    input  oADC_CH,
    output iADC_ACK,
    output iADC_DATA
  );
endinterface

// File: rtl/meas_tick_gen.sv
// Free-running scan-start tick generator.
//   clk, rst_n : shared system clock, asynchronous active-low reset
//   tick       : high for one cycle when the counter sits at REFRESH_DIV-1
module meas_tick_gen #(
  parameter int unsigned REFRESH_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned   CntW   = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tick = (count_q == CntMax);

  always_comb begin
    count_d = tick ? '0 : count_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lcd_meas_scheduler.sv
// Periodic four-channel ADC scan with a coherent snapshot for the LCD path.
// Each scan requests Vin, Vout, Iout, Temp in turn over one shared req/ack
// port, gathers results in shadow registers and copies all four to the
// outputs at once, pulsing oUPDATE in the first cycle they are visible.
//   iCLK_50MHZ, iRST_N : clock, asynchronous active-low reset
//   iEN                : scan enable, only looked at in IDLE
//   adc                : ADC req/ack port (master side)
//   oVIN..oTEMP        : committed snapshot
//   oSTALE             : per-channel timeout flags, committed with the snapshot
//   oUPDATE            : one-cycle commit strobe
//   oBUSY              : scan in progress
// Build option: define MEAS_TIMEOUT_EN to enable the per-request timeout and
// stale flags; otherwise REQ waits forever and oSTALE is constant zero.
module lcd_meas_scheduler
  import lcd_meas_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                        iCLK_50MHZ,
  input  logic                        iRST_N,
  input  logic                        iEN,
  lcd_meas_scheduler_if.master        adc,
  output logic [7:0]                  oVIN,
  output logic [7:0]                  oVOUT,
  output logic [7:0]                  oIOUT,
  output logic [7:0]                  oTEMP,
  output logic [3:0]                  oSTALE,
  output logic                        oUPDATE,
  output logic                        oBUSY
);

  if (REFRESH_DIV < 16) begin : g_bad_refresh_div
    $error("REFRESH_DIV must be at least 16");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout_cyc
    $error("TIMEOUT_CYC must be at least 2");
  end

  meas_state_e state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic        req_q, busy_q, upd_q;
  logic        tick;
  logic        cap_en;       // ack seen in REQ: latch data for ch_q
  logic        stale_en;     // timeout in REQ: mark ch_q stale
  logic        timeout_hit;

  logic [7:0]  shadow_q [NUM_CH];
  logic [7:0]  out_q    [NUM_CH];

  meas_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick_gen (
    .clk   (iCLK_50MHZ),
    .rst_n (iRST_N),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cap_en   = 1'b0;
    stale_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ticks elsewhere are simply lost, so at most one scan is ever pending.
        if (tick && iEN) begin
          state_d = REQ;
          ch_d    = CH_VIN;
        end
      end
      REQ: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (adc.iADC_ACK) begin
          cap_en  = 1'b1;
          state_d = NEXT;
        end else if (timeout_hit) begin
          stale_en = 1'b1;
          state_d  = NEXT;
        end
      end
      NEXT: begin
        if (ch_q == CH_TEMP) begin
          state_d = COMMIT;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = REQ;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      ch_q    <= CH_VIN;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      req_q   <= (state_d == REQ);
      busy_q  <= (state_d != IDLE);
      upd_q   <= (state_q == COMMIT);
    end
  end

  // Shadow fills during the scan; outputs only ever change as a full set.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      if (cap_en) begin
        shadow_q[ch_q] <= adc.iADC_DATA;
      end else if (stale_en) begin
        shadow_q[ch_q] <= STALE_VAL;
      end
      if (state_q == COMMIT) begin
        out_q <= shadow_q;
      end
    end
  end

`ifdef MEAS_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);

  logic [TmoW-1:0]   tmo_q;
  logic [NUM_CH-1:0] stale_shadow_q, stale_q;

  assign timeout_hit = (state_q == REQ) && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  // Counter is zero on the first REQ cycle because it is held clear outside REQ.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      tmo_q <= '0;
    end else if (state_q == REQ) begin
      tmo_q <= tmo_q + TmoW'(1);
    end else begin
      tmo_q <= '0;
    end
  end

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      stale_shadow_q <= '0;
      stale_q        <= '0;
    end else begin
      if (cap_en) begin
        stale_shadow_q[ch_q] <= 1'b0;
      end else if (stale_en) begin
        stale_shadow_q[ch_q] <= 1'b1;
      end
      if (state_q == COMMIT) begin
        stale_q <= stale_shadow_q;
      end
    end
  end

  assign oSTALE = stale_q;
`else
  assign timeout_hit = 1'b0;
  assign oSTALE      = 4'b0000;
`endif

  assign adc.oADC_REQ = req_q;
  assign adc.oADC_CH  = ch_q;
  assign oVIN         = out_q[CH_VIN];
  assign oVOUT        = out_q[CH_VOUT];
  assign oIOUT        = out_q[CH_IOUT];
  assign oTEMP        = out_q[CH_TEMP];
  assign oUPDATE      = upd_q;
  assign oBUSY        = busy_q;

endmodule

// File: tb/tb_lcd_meas_scheduler.sv
// Bench for lcd_meas_scheduler: each phase resets the DUT, the bench plays
// the ADC from a precomputed scan timeline and compares every cycle.
module tb_lcd_meas_scheduler;
  import lcd_meas_pkg::*;

  localparam int unsigned RDiv = 16;
  localparam int unsigned Tmo  = 8;
  localparam int          MaxL = 128;
`ifdef MEAS_TIMEOUT_EN
  localparam int          NPh  = 6;
`else
  localparam int          NPh  = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] vin, vout, iout, temp;
  logic [3:0] stale;
  logic       upd, busy;

  lcd_meas_scheduler_if adc ();

  lcd_meas_scheduler #(
    .REFRESH_DIV (RDiv),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .iEN        (en),
    .adc        (adc),
    .oVIN       (vin),
    .oVOUT      (vout),
    .oIOUT      (iout),
    .oTEMP      (temp),
    .oSTALE     (stale),
    .oUPDATE    (upd),
    .oBUSY      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ph    = 0;
  int cur_c = 0;
  bit checking = 1'b0;

  // Expected per-cycle behaviour of the current phase.
  logic       e_req  [MaxL];
  logic [1:0] e_ch   [MaxL];
  logic       e_busy [MaxL];
  logic       e_upd  [MaxL];
  logic [7:0] e_out  [MaxL][4];
  logic [3:0] e_stl  [MaxL];
  logic       ack_at [MaxL];
  logic [7:0] ack_dat[MaxL];

  // Phase table: 0 basic, 1 slow ADC, 2 iEN drop, 3 reset mid-scan,
  // 4 rescan after reset, 5 Iout timeout (timeout build only).
  function automatic int ph_len(input int p);
    case (p)
      2: return 100;
      3: return 80;
      4: return 30;
      5: return 70;
      default: return 60;
    endcase
  endfunction

  function automatic int ph_delay(input int p);
    case (p)
      1: return 5;
      2: return 1;
      3: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int ph_rst(input int p);
    return (p == 3) ? 57 : 1000;
  endfunction

  function automatic int ph_bad(input int p);
    return (p == 5) ? 2 : -1;
  endfunction

  function automatic bit en_of(input int p, input int c);
    return !((p == 2) && (c >= 20) && (c < 70));
  endfunction

  function automatic logic [7:0] data_of(input int p, input int j, input int k);
    int v;
    v = 'h12 + 'h22 * k + 5 * j + 'h40 * p;
    return v[7:0];
  endfunction

  // Scan-level timeline: per channel, REQ for delay+1 cycles then one idle
  // cycle; after Temp one more cycle, then the snapshot appears.
  task automatic build_model(input int p);
    int len, dly, rst_at, bad_ch, busy_until, scan, s, dd;
    logic [7:0] sh[4];
    logic [3:0] ssh;
    bit st;
    len = ph_len(p); dly = ph_delay(p); rst_at = ph_rst(p); bad_ch = ph_bad(p);
    for (int c = 0; c < MaxL; c++) begin
      e_req[c] = 1'b0; e_ch[c] = 2'd0; e_busy[c] = 1'b0; e_upd[c] = 1'b0;
      e_stl[c] = 4'd0; ack_at[c] = 1'b0; ack_dat[c] = 8'd0;
      for (int k = 0; k < 4; k++) e_out[c][k] = 8'd0;
    end
    busy_until = 0; scan = 0; ssh = 4'd0;
    for (int k = 0; k < 4; k++) sh[k] = 8'd0;
    for (int c = 0; c < len; c++) begin
      if ((c % RDiv == RDiv - 1) && en_of(p, c) && (c >= busy_until) && (c < rst_at)) begin
        s = c + 1;
        for (int k = 0; k < 4; k++) begin
          st = (bad_ch == k) && (scan == 0);
          dd = st ? Tmo - 1 : dly;
          for (int t = s; t <= s + dd; t++) begin
            if (t < len) begin e_req[t] = 1'b1; e_ch[t] = 2'(k); end
          end
          if (st) begin
            sh[k] = 8'hFF; ssh[k] = 1'b1;
          end else begin
            sh[k] = data_of(p, scan, k); ssh[k] = 1'b0;
            if (s + dd < len) begin ack_at[s + dd] = 1'b1; ack_dat[s + dd] = sh[k]; end
          end
          s = s + dd + 2;
        end
        for (int t = c + 1; t <= s; t++) if (t < len) e_busy[t] = 1'b1;
        if (s + 1 < len) e_upd[s + 1] = 1'b1;
        for (int t = s + 1; t < len; t++) begin
          for (int k = 0; k < 4; k++) e_out[t][k] = sh[k];
          e_stl[t] = ssh;
        end
        busy_until = s + 1;
        scan++;
      end
    end
    // Spurious acks whenever no request is outstanding.
    for (int c = 0; c < len; c++) begin
      if (!e_req[c] && (c % 5 == 2)) begin ack_at[c] = 1'b1; ack_dat[c] = 8'hEE; end
    end
    for (int c = rst_at; c < len; c++) begin
      e_req[c] = 1'b0; e_busy[c] = 1'b0; e_upd[c] = 1'b0; e_stl[c] = 4'd0;
      for (int k = 0; k < 4; k++) e_out[c][k] = 8'd0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s phase=%0d cyc=%0d got=%0h want=%0h", nm, ph, cur_c, act, exp);
    end
  endtask

  task automatic drive(input int c);
    en            = en_of(ph, c);
    adc.iADC_ACK  = ack_at[c];
    adc.iADC_DATA = ack_at[c] ? ack_dat[c] : 8'h00;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("req", {31'd0, adc.oADC_REQ}, {31'd0, e_req[cur_c]});
      if (e_req[cur_c]) chk("ch", {30'd0, adc.oADC_CH}, {30'd0, e_ch[cur_c]});
      chk("busy", {31'd0, busy}, {31'd0, e_busy[cur_c]});
      chk("update", {31'd0, upd}, {31'd0, e_upd[cur_c]});
      chk("vin", {24'd0, vin}, {24'd0, e_out[cur_c][0]});
      chk("vout", {24'd0, vout}, {24'd0, e_out[cur_c][1]});
      chk("iout", {24'd0, iout}, {24'd0, e_out[cur_c][2]});
      chk("temp", {24'd0, temp}, {24'd0, e_out[cur_c][3]});
      chk("stale", {28'd0, stale}, {28'd0, e_stl[cur_c]});
      // Hand-derived anchor points.
      if (ph == 0 && cur_c == 0)  chk("lit_rst_busy", {31'd0, busy}, 32'd0);
      if (ph == 0 && cur_c == 15) chk("lit_req15", {31'd0, adc.oADC_REQ}, 32'd0);
      if (ph == 0 && cur_c == 16) chk("lit_req16", {31'd0, adc.oADC_REQ}, 32'd1);
      if (ph == 0 && cur_c == 24) chk("lit_vin_pre", {24'd0, vin}, 32'h00);
      if (ph == 0 && cur_c == 25) begin
        chk("lit_upd25", {31'd0, upd}, 32'd1);
        chk("lit_vin", {24'd0, vin}, 32'h12);
        chk("lit_vout", {24'd0, vout}, 32'h34);
        chk("lit_iout", {24'd0, iout}, 32'h56);
        chk("lit_temp", {24'd0, temp}, 32'h78);
      end
      if (ph == 1 && cur_c == 21) chk("lit_slow_req", {31'd0, adc.oADC_REQ}, 32'd1);
      if (ph == 1 && cur_c == 22) chk("lit_slow_gap", {31'd0, adc.oADC_REQ}, 32'd0);
      if (ph == 1 && cur_c == 23) chk("lit_slow_ch1", {30'd0, adc.oADC_CH}, 32'd1);
      if (ph == 1 && cur_c == 45) chk("lit_slow_upd", {31'd0, upd}, 32'd1);
      if (ph == 2 && cur_c == 29) chk("lit_en_upd", {31'd0, upd}, 32'd1);
      if (ph == 2 && cur_c == 63) chk("lit_en_idle", {31'd0, busy}, 32'd0);
      if (ph == 2 && cur_c == 93) chk("lit_en_upd2", {31'd0, upd}, 32'd1);
      if (ph == 3 && cur_c == 56) chk("lit_abort_pre", {24'd0, vin}, 32'hD2);
      if (ph == 3 && cur_c == 57) chk("lit_abort_vin", {24'd0, vin}, 32'h00);
      if (ph == 4 && cur_c == 16) chk("lit_rescan_ch", {30'd0, adc.oADC_CH}, 32'd0);
      if (ph == 5 && cur_c == 32) begin
        chk("lit_tmo_iout", {24'd0, iout}, 32'hFF);
        chk("lit_tmo_stale", {28'd0, stale}, 32'h4);
      end
      if (ph == 5 && cur_c == 57) begin
        chk("lit_tmo_clear", {28'd0, stale}, 32'h0);
        chk("lit_tmo_iout2", {24'd0, iout}, 32'h9B);
      end
    end
  end

  initial begin
    adc.iADC_ACK  = 1'b0;
    adc.iADC_DATA = 8'h00;
    for (int p = 0; p < NPh; p++) begin
      build_model(p);
      ph    = p;
      rst_n = 1'b0;
      en    = 1'b0;
      adc.iADC_ACK = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      cur_c    = 0;
      drive(0);
      checking = 1'b1;
      for (int c = 1; c < ph_len(p); c++) begin
        @(posedge clk);
        #1;
        cur_c = c;
        if (c == ph_rst(p)) rst_n = 1'b0;
        drive(c);
      end
      @(negedge clk);
      #1;
      checking = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
